// File: rtl/jtcop_obj_pkg.sv
// Shared constants and helpers for the object line buffer.
package jtcop_obj_pkg;

    localparam int OBJ_AW   = 9;
    localparam int OBJ_DW   = 8;
    localparam int COLOUR_W = 4;

    localparam logic [COLOUR_W-1:0] TRANSPARENT = 4'h0;

    function automatic logic is_opaque(input logic [COLOUR_W-1:0] colour);
        return colour != TRANSPARENT;
    endfunction

endpackage

// File: rtl/jtcop_obj_buffer_if.sv
// Renderer-side bus of the object line buffer: draw requests in, line sync out.
interface jtcop_obj_buffer_if
    import jtcop_obj_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) ();

    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic          buf_we;
    logic          line_start;
    logic          draw_bank;

    modport master (
        output buf_addr,
        output buf_data,
        output buf_we,
        input  line_start,
        input  draw_bank
    );

    modport slave (
        input  buf_addr,
        input  buf_data,
        input  buf_we,
        output line_start,
        output draw_bank
    );

endinterface

// File: rtl/jtcop_obj_lbuf.sv
// One line-buffer bank: a read-modify-write port for drawing and a
// read/erase port for scan-out, each enabled only when it targets this bank.
module jtcop_obj_lbuf
    import jtcop_obj_pkg::*;
#(
    parameter int   AW   = OBJ_AW,
    parameter int   DW   = OBJ_DW,
    parameter logic BANK = 1'b0
) (
    input  logic          clk,
    input  logic          rd_a_bank,
    input  logic          rd_a_en,
    input  logic [AW-1:0] rd_a_addr,
    output logic [DW-1:0] a_dout,
    input  logic          wr_a_bank,
    input  logic          wr_a_en,
    input  logic [AW-1:0] wr_a_addr,
    input  logic [DW-1:0] wr_a_data,
    input  logic          rd_b_bank,
    input  logic          rd_b_en,
    input  logic [AW-1:0] rd_b_addr,
    output logic [DW-1:0] b_dout,
    input  logic          er_b_bank,
    input  logic          er_b_en,
    input  logic [AW-1:0] er_b_addr
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] a_dout_q;
    logic [DW-1:0] b_dout_q;
    logic          a_rd;
    logic          a_wr;
    logic          b_rd;
    logic          b_er;
    logic [AW-1:0] b_addr;

    always_comb begin
        a_rd   = rd_a_en && (rd_a_bank == BANK);
        a_wr   = wr_a_en && (wr_a_bank == BANK);
        b_rd   = rd_b_en && (rd_b_bank == BANK);
        b_er   = er_b_en && (er_b_bank == BANK);
        b_addr = b_er ? er_b_addr : rd_b_addr;
    end

    // Output registers hold between reads; a draw write lands after an erase
    // of the same word so in-flight pixels are never lost.
    always_ff @(posedge clk) begin
        if (a_rd) begin
            a_dout_q <= mem[rd_a_addr];
        end
        if (b_rd && !b_er) begin
            b_dout_q <= mem[b_addr];
        end
        if (b_er) begin
            mem[b_addr] <= '0;
        end
        if (a_wr) begin
            mem[wr_a_addr] <= wr_a_data;
        end
    end

    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;

endmodule

// File: rtl/jtcop_obj_buffer.sv
// Double object line buffer: first-opaque-wins draw pipeline into one bank,
// pixel-rate scan-out with erase-after-read from the other.
module jtcop_obj_buffer
    import jtcop_obj_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pxl_cen,
    input  logic              LHBL,
    input  logic [AW-1:0]     hdump,
    input  logic              flip,
    jtcop_obj_buffer_if.slave bus,
    output logic [DW-1:0]     obj_pxl
);

    logic          lhbl_q, lhbl_d;
    logic          draw_bank_q, draw_bank_d;
    logic          line_start_q, line_start_d;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_bank_q, s1_bank_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic [DW-1:0] s1_data_q, s1_data_d;

    logic          s2_valid_q, s2_valid_d;
    logic          s2_bank_q, s2_bank_d;
    logic [AW-1:0] s2_addr_q, s2_addr_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic          s2_fwd_q, s2_fwd_d;
    logic [DW-1:0] s2_fwd_pxl_q, s2_fwd_pxl_d;

    logic          erase_q, erase_d;
    logic          erase_bank_q, erase_bank_d;
    logic [AW-1:0] erase_addr_q, erase_addr_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] obj_pxl_q, obj_pxl_d;

    logic          swap;
    logic          s2_write;
    logic [DW-1:0] s2_old;
    logic          scan_bank;
    logic          scan_rd;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] rd_pxl;
    logic [DW-1:0] a_dout [2];
    logic [DW-1:0] b_dout [2];

    // Draw side: the request captures the draw bank seen before any swap in
    // the same clk and keeps it while in flight.
    always_comb begin
        swap         = lhbl_q & ~LHBL;
        lhbl_d       = LHBL;
        draw_bank_d  = draw_bank_q ^ swap;
        line_start_d = swap;

        s1_valid_d = bus.buf_we;
        s1_bank_d  = draw_bank_q;
        s1_addr_d  = bus.buf_addr;
        s1_data_d  = bus.buf_data;

        s2_old   = s2_fwd_q ? s2_fwd_pxl_q : a_dout[s2_bank_q];
        s2_write = s2_valid_q && is_opaque(s2_data_q[COLOUR_W-1:0])
                   && !is_opaque(s2_old[COLOUR_W-1:0]);

        s2_valid_d   = s1_valid_q;
        s2_bank_d    = s1_bank_q;
        s2_addr_d    = s1_addr_q;
        s2_data_d    = s1_data_q;
        // The RAM read in S1 misses a write to the same word in S2.
        s2_fwd_d     = s2_write && (s2_addr_q == s1_addr_q) && (s2_bank_q == s1_bank_q);
        s2_fwd_pxl_d = s2_data_q;
    end

    always_comb begin
        scan_bank = ~draw_bank_q;
        scan_addr = flip ? ~hdump : hdump;
        scan_rd   = pxl_cen & LHBL;
        rd_pxl    = b_dout[erase_bank_q];

        erase_d      = scan_rd;
        erase_addr_d = erase_addr_q;
        erase_bank_d = erase_bank_q;
        rd_valid_d   = rd_valid_q;
        obj_pxl_d    = obj_pxl_q;

        if (scan_rd) begin
            erase_addr_d = scan_addr;
            erase_bank_d = scan_bank;
        end
        // A blanked pixel slot outputs nothing and invalidates the pending read.
        if (pxl_cen) begin
            obj_pxl_d  = (LHBL && rd_valid_q) ? rd_pxl : '0;
            rd_valid_d = LHBL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhbl_q       <= 1'b0;
            draw_bank_q  <= 1'b0;
            line_start_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_bank_q    <= 1'b0;
            s1_addr_q    <= '0;
            s1_data_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_bank_q    <= 1'b0;
            s2_addr_q    <= '0;
            s2_data_q    <= '0;
            s2_fwd_q     <= 1'b0;
            s2_fwd_pxl_q <= '0;
            erase_q      <= 1'b0;
            erase_bank_q <= 1'b0;
            erase_addr_q <= '0;
            rd_valid_q   <= 1'b0;
            obj_pxl_q    <= '0;
        end else begin
            lhbl_q       <= lhbl_d;
            draw_bank_q  <= draw_bank_d;
            line_start_q <= line_start_d;
            s1_valid_q   <= s1_valid_d;
            s1_bank_q    <= s1_bank_d;
            s1_addr_q    <= s1_addr_d;
            s1_data_q    <= s1_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_bank_q    <= s2_bank_d;
            s2_addr_q    <= s2_addr_d;
            s2_data_q    <= s2_data_d;
            s2_fwd_q     <= s2_fwd_d;
            s2_fwd_pxl_q <= s2_fwd_pxl_d;
            erase_q      <= erase_d;
            erase_bank_q <= erase_bank_d;
            erase_addr_q <= erase_addr_d;
            rd_valid_q   <= rd_valid_d;
            obj_pxl_q    <= obj_pxl_d;
        end
    end

    jtcop_obj_lbuf #(.AW(AW), .DW(DW), .BANK(1'b0)) u_bank0 (
        .clk       (clk),
        .rd_a_bank (s1_bank_q),
        .rd_a_en   (s1_valid_q),
        .rd_a_addr (s1_addr_q),
        .a_dout    (a_dout[0]),
        .wr_a_bank (s2_bank_q),
        .wr_a_en   (s2_write),
        .wr_a_addr (s2_addr_q),
        .wr_a_data (s2_data_q),
        .rd_b_bank (scan_bank),
        .rd_b_en   (scan_rd),
        .rd_b_addr (scan_addr),
        .b_dout    (b_dout[0]),
        .er_b_bank (erase_bank_q),
        .er_b_en   (erase_q),
        .er_b_addr (erase_addr_q)
    );

    jtcop_obj_lbuf #(.AW(AW), .DW(DW), .BANK(1'b1)) u_bank1 (
        .clk       (clk),
        .rd_a_bank (s1_bank_q),
        .rd_a_en   (s1_valid_q),
        .rd_a_addr (s1_addr_q),
        .a_dout    (a_dout[1]),
        .wr_a_bank (s2_bank_q),
        .wr_a_en   (s2_write),
        .wr_a_addr (s2_addr_q),
        .wr_a_data (s2_data_q),
        .rd_b_bank (scan_bank),
        .rd_b_en   (scan_rd),
        .rd_b_addr (scan_addr),
        .b_dout    (b_dout[1]),
        .er_b_bank (erase_bank_q),
        .er_b_en   (erase_q),
        .er_b_addr (erase_addr_q)
    );

    assign bus.line_start = line_start_q;
    assign bus.draw_bank  = draw_bank_q;
    assign obj_pxl        = obj_pxl_q;

endmodule

// File: tb/tb_jtcop_obj_buffer.sv
// Directed bench for the object line buffer: swap, draw priority, flip,
// erase-after-read and blanking behaviour.
module tb_jtcop_obj_buffer;
    import jtcop_obj_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pxl_cen;
    logic       LHBL;
    logic       flip;
    logic [8:0] hdump;
    logic [7:0] obj_pxl;
    logic       exp_bank;
    int         total = 0;
    int         bad   = 0;

    jtcop_obj_buffer_if #(.AW(9), .DW(8)) bus ();

    jtcop_obj_buffer #(.AW(9), .DW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pxl_cen (pxl_cen),
        .LHBL    (LHBL),
        .hdump   (hdump),
        .flip    (flip),
        .bus     (bus),
        .obj_pxl (obj_pxl)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pixel slot: pxl_cen for one clk, then one idle clk for the erase.
    task automatic pixel(input logic [8:0] h);
        hdump   = h;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        tick();
    endtask

    task automatic draw(input logic [8:0] a, input logic [7:0] d);
        bus.buf_we   = 1'b1;
        bus.buf_addr = a;
        bus.buf_data = d;
        tick();
        bus.buf_we = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic do_swap();
        LHBL = 1'b0;
        tick();
        tick();
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        tick();
        LHBL = 1'b1;
        tick();
        exp_bank = ~exp_bank;
    endtask

    task automatic test_power_on();
        rst_n = 1'b0;
        tick();
        tick();
        if (obj_pxl !== 8'h00) begin
            bad++;
            $display("[TB] FAIL por_obj_pxl got %h want 00", obj_pxl);
        end
        total++;
        if (bus.draw_bank !== 1'b0) begin
            bad++;
            $display("[TB] FAIL por_draw_bank got %b want 0", bus.draw_bank);
        end
        total++;
        if (bus.line_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL por_line_start got %b want 0", bus.line_start);
        end
        total++;
        rst_n = 1'b1;
        tick();
        exp_bank = 1'b0;
    endtask

    // Scan every column of both banks so the erase leaves them empty.
    task automatic test_clear();
        for (int i = 0; i < 512; i++) pixel(9'(i));
        do_swap();
        for (int i = 0; i < 512; i++) pixel(9'(i));
        do_swap();
    endtask

    task automatic test_reset();
        draw(9'd40, 8'h5D);
        do_swap();
        pixel(9'd40);
        pixel(9'd41);
        if (obj_pxl !== 8'h5D) begin
            bad++;
            $display("[TB] FAIL rst_pre_pxl got %h want 5d", obj_pxl);
        end
        total++;
        if (bus.draw_bank !== exp_bank) begin
            bad++;
            $display("[TB] FAIL rst_pre_bank got %b want %b", bus.draw_bank, exp_bank);
        end
        total++;
        hdump   = 9'd42;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        if (obj_pxl !== 8'h00) begin
            bad++;
            $display("[TB] FAIL rst_obj_pxl got %h want 00", obj_pxl);
        end
        total++;
        if (bus.draw_bank !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_draw_bank got %b want 0", bus.draw_bank);
        end
        total++;
        if (bus.line_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_line_start got %b want 0", bus.line_start);
        end
        total++;
        tick();
        rst_n = 1'b1;
        tick();
        exp_bank = 1'b0;
        LHBL = 1'b0;
        tick();
        if (bus.draw_bank !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_swap_bank got %b want 1", bus.draw_bank);
        end
        total++;
        if (bus.line_start !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_swap_pulse got %b want 1", bus.line_start);
        end
        total++;
        tick();
        if (bus.line_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_swap_pulse_end got %b want 0", bus.line_start);
        end
        total++;
        LHBL = 1'b1;
        tick();
        exp_bank = 1'b1;
    endtask

    task automatic test_basic_line();
        draw(9'd5, 8'h23);
        do_swap();
        pixel(9'd5);
        pixel(9'd6);
        if (obj_pxl !== 8'h23) begin
            bad++;
            $display("[TB] FAIL basic_read got %h want 23", obj_pxl);
        end
        total++;
        do_swap();
        do_swap();
        pixel(9'd5);
        pixel(9'd6);
        if (obj_pxl !== 8'h00) begin
            bad++;
            $display("[TB] FAIL basic_erased got %h want 00", obj_pxl);
        end
        total++;
    endtask

    task automatic test_priority();
        bus.buf_we   = 1'b1;
        bus.buf_addr = 9'd7;
        bus.buf_data = 8'h41;
        tick();
        bus.buf_data = 8'h52;
        tick();
        bus.buf_addr = 9'd10;
        bus.buf_data = 8'h30;
        tick();
        bus.buf_data = 8'h47;
        tick();
        bus.buf_we = 1'b0;
        tick();
        tick();
        tick();
        draw(9'd8, 8'h30);
        draw(9'd11, 8'h12);
        draw(9'd11, 8'h34);
        do_swap();
        pixel(9'd7);
        pixel(9'd8);
        if (obj_pxl !== 8'h41) begin
            bad++;
            $display("[TB] FAIL prio_forward got %h want 41", obj_pxl);
        end
        total++;
        pixel(9'd10);
        if (obj_pxl !== 8'h00) begin
            bad++;
            $display("[TB] FAIL prio_transparent got %h want 00", obj_pxl);
        end
        total++;
        pixel(9'd11);
        if (obj_pxl !== 8'h47) begin
            bad++;
            $display("[TB] FAIL prio_after_transparent got %h want 47", obj_pxl);
        end
        total++;
        pixel(9'd12);
        if (obj_pxl !== 8'h12) begin
            bad++;
            $display("[TB] FAIL prio_ram_path got %h want 12", obj_pxl);
        end
        total++;
    endtask

    task automatic test_flip();
        flip = 1'b1;
        draw(9'h1FA, 8'h6C);
        do_swap();
        pixel(9'd5);
        pixel(9'd6);
        if (obj_pxl !== 8'h6C) begin
            bad++;
            $display("[TB] FAIL flip_read got %h want 6c", obj_pxl);
        end
        total++;
        flip = 1'b0;
    endtask

    task automatic test_swap_collision();
        LHBL         = 1'b0;
        bus.buf_we   = 1'b1;
        bus.buf_addr = 9'd20;
        bus.buf_data = 8'h7E;
        tick();
        bus.buf_we = 1'b0;
        exp_bank   = ~exp_bank;
        if (bus.draw_bank !== exp_bank) begin
            bad++;
            $display("[TB] FAIL coll_bank got %b want %b", bus.draw_bank, exp_bank);
        end
        total++;
        if (bus.line_start !== 1'b1) begin
            bad++;
            $display("[TB] FAIL coll_pulse got %b want 1", bus.line_start);
        end
        total++;
        tick();
        tick();
        LHBL = 1'b1;
        tick();
        pixel(9'd20);
        pixel(9'd21);
        if (obj_pxl !== 8'h7E) begin
            bad++;
            $display("[TB] FAIL coll_read got %h want 7e", obj_pxl);
        end
        total++;
    endtask

    task automatic test_blanking();
        draw(9'd30, 8'h9A);
        LHBL = 1'b0;
        tick();
        tick();
        exp_bank = ~exp_bank;
        hdump    = 9'd30;
        pxl_cen  = 1'b1;
        tick();
        pxl_cen = 1'b0;
        tick();
        if (obj_pxl !== 8'h00) begin
            bad++;
            $display("[TB] FAIL blank_out got %h want 00", obj_pxl);
        end
        total++;
        LHBL = 1'b1;
        tick();
        pixel(9'd30);
        pixel(9'd31);
        if (obj_pxl !== 8'h9A) begin
            bad++;
            $display("[TB] FAIL blank_no_erase got %h want 9a", obj_pxl);
        end
        total++;
        if (bus.draw_bank !== exp_bank) begin
            bad++;
            $display("[TB] FAIL blank_bank got %b want %b", bus.draw_bank, exp_bank);
        end
        total++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        pxl_cen      = 1'b0;
        LHBL         = 1'b1;
        flip         = 1'b0;
        hdump        = '0;
        exp_bank     = 1'b0;
        bus.buf_we   = 1'b0;
        bus.buf_addr = '0;
        bus.buf_data = '0;
        test_power_on();
        test_clear();
        test_reset();
        test_basic_line();
        test_priority();
        test_flip();
        test_swap_collision();
        test_blanking();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
